seg_display_scan: RTL and testbench
===================================

# seg_display_scan

Multiplexed 8-position 7-segment display driver sitting directly downstream of the watch/time-keeping stage. It takes the six BCD time digits (HH MM SS) plus set-mode cursor and alarm-flash status, and drives the shared `seg_data`/`seg_com` bus one position per scan slot. The display reads as `HH-MM-SS`. Digits are snapshotted once per frame so the display never shows a torn value mid-carry.

## Interface
- `SCAN_DIV`, 1: clk cycles per scan slot; ≥1. At the 1 kHz system clock this gives a 125 Hz frame rate.
- `BLINK_HALF`, 500: clk cycles per blink half-period; ≥2.

- `clk`  in  1  system clock, 1 kHz nominal.
- `rst`  in  1  reset, asynchronous, active-low.
- `h_ten, h_one, m_ten, m_one, s_ten, s_one`  in  4 each  BCD time digits.
- `set_mode`  in  1  1 = time-set mode; the cursor digit blinks.
- `edit_pos`  in  3  cursor digit: 0=h_ten, 1=h_one, 2=m_ten, 3=m_one, 4=s_ten, 5=s_one; 6–7 = no cursor.
- `alarm_flash`  in  1  1 = whole display blinks.
- `seg_data`  out  8  segments `{a,b,c,d,e,f,g,dp}`, active-high, registered.
- `seg_com`  out  8  position select, active-low, one-cold, registered; bit 7 is the leftmost position.

## Operation
- Scan index `idx` (0–7) maps left to right as: 0 h_ten, 1 h_one, 2 separator, 3 m_ten, 4 m_one, 5 separator, 6 s_ten, 7 s_one.
- Slot counter `div` counts 0..SCAN_DIV-1.
  - When `div` = SCAN_DIV-1, `div` returns to 0 and `idx` increments, wrapping 7→0.
- Snapshot register holds all six digits.
  - It loads on the edge where `idx`=7 and `div`=SCAN_DIV-1 (frame wrap).
  - Input changes at any other time are invisible until the next frame.
- Digit decode: 0 FC, 1 60, 2 DA, 3 F2, 4 66, 5 B6, 6 BE, 7 E0, 8 FE, 9 F6.
  - Values 10–15 decode to 00 (blank).
  - Separators decode to 02 (segment g). The dp segment is always 0.
- `seg_com` for index i is 8'hFF with bit (7−i) cleared: 7F, BF, DF, EF, F7, FB, FD, FE.
  - `seg_com` stays one-cold even when the data is blanked.
- Blink generator:
  - Counter `bcnt` counts 0..BLINK_HALF-1. At wrap it toggles `phase`. `phase`=1 means visible.
  - A rising edge of `set_mode` or of `alarm_flash` (registered edge detect) forces `bcnt`=0 and `phase`=1 on the next edge, so the cursor is visible immediately.
- Blanking rules, applied to `seg_data` only:
  - If `alarm_flash`=1 and `phase`=0, all 8 positions show 00. This has priority.
  - Otherwise, if `set_mode`=1, `edit_pos`≤5, `phase`=0 and `idx` is the cursor's position, that position shows 00.
  - Separators never blink for the cursor.
- `edit_pos` and the mode inputs are sampled live every cycle. They are not snapshotted.

## Timing
- Reset values while `rst`=0:
  - `seg_data`=00, `seg_com`=FF.
  - `idx`=0, `div`=0, `bcnt`=0, `phase`=1, snapshot all 0, edge-detect registers 0.
- Output latency: the outputs registered at edge k reflect the `idx`, snapshot, `phase` and mode values present before edge k (one-cycle pipeline).
  - First edge after reset release: `seg_com`=7F, `seg_data`=FC (snapshot is 0).
- With SCAN_DIV=1, `idx` advances every edge and a full frame takes 8 cycles. The snapshot captured at the frame-7 edge is first displayed at position 0 on the edge after that.
- Reset asserted mid-frame: all state clears asynchronously and `seg_com` goes to FF immediately, with no clock required.
- A mode rising edge coincident with a `bcnt` wrap: the force-visible wins, so `phase`=1 and `bcnt`=0.
- `set_mode` and `alarm_flash` both high: the alarm blanking rule governs.

## Test plan
- Reset: hold `rst`=0 for 5 clocks → `seg_com`=FF, `seg_data`=00. Release → first edge gives 7F/FC.
- Digits 1,2,3,4,5,6, SCAN_DIV=1, after one frame: `seg_com` sequence 7F, BF, DF, EF, F7, FB, FD, FE with `seg_data` 60, DA, 02, F2, 66, 02, B6, BE, repeating.
- Tear-free snapshot: change `s_one` 6→7 while `idx`=3 → position 7 still shows BE this frame and E0 from the next frame.
- Cursor blink: `set_mode`↑ with `edit_pos`=3, BLINK_HALF=500:
  - Position 4 (`seg_com` F7) shows 66 for 500 cycles, then 00 for 500 cycles.
  - Other positions are unchanged throughout.
- Alarm flash: `alarm_flash`=1 together with `set_mode`=1 → all positions show 00 during `phase`=0, and the normal frame during `phase`=1.
- Invalid digit and reset mid-operation:
  - `m_ten`=4'hA → position 3 shows 00.
  - Assert `rst` at `idx`=5 → `seg_com`=FF asynchronously, and the scan restarts at 7F after release.

Source files
------------

// File: rtl/seg_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_scan
// Description : 8-position multiplexed 7-segment driver showing HH-MM-SS with
//               frame-coherent digit snapshot, cursor blink and alarm flash.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_display_scan #(
    parameter int SCAN_DIV   = 1,
    parameter int BLINK_HALF = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] h_ten,
    input  logic [3:0] h_one,
    input  logic [3:0] m_ten,
    input  logic [3:0] m_one,
    input  logic [3:0] s_ten,
    input  logic [3:0] s_one,
    input  logic       set_mode,
    input  logic [2:0] edit_pos,
    input  logic       alarm_flash,
    output logic [7:0] seg_data,
    output logic [7:0] seg_com
);

    localparam int c_div_w  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_bcnt_w = $clog2(BLINK_HALF);
    localparam logic [c_div_w-1:0]  c_div_last  = c_div_w'(SCAN_DIV - 1);
    localparam logic [c_bcnt_w-1:0] c_bcnt_last = c_bcnt_w'(BLINK_HALF - 1);
    localparam logic [7:0]          c_seg_sep   = 8'h02;

    logic [c_div_w-1:0]  r_div;
    logic [2:0]          r_idx;
    logic [5:0][3:0]     r_snap;
    logic [c_bcnt_w-1:0] r_bcnt;
    logic                r_phase;
    logic                r_set_d;
    logic                r_alarm_d;

    logic                w_slot_end;
    logic                w_frame_end;
    logic                w_rise;
    logic [3:0]          w_digit;
    logic                w_is_sep;
    logic [7:0]          w_glyph;
    logic                w_cursor_vld;
    logic [2:0]          w_cursor_idx;
    logic                w_blank;

    assign w_slot_end  = (r_div == c_div_last);
    assign w_frame_end = w_slot_end && (r_idx == 3'd7);
    assign w_rise      = (set_mode & ~r_set_d) | (alarm_flash & ~r_alarm_d);

    // Scan position, slot divider and per-frame digit snapshot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div  <= '0;
            r_idx  <= 3'd0;
            r_snap <= '0;
        end else begin
            if (w_slot_end) begin
                r_div <= '0;
                r_idx <= r_idx + 3'd1;
            end else begin
                r_div <= r_div + 1'b1;
            end
            if (w_frame_end) begin
                r_snap <= {h_ten, h_one, m_ten, m_one, s_ten, s_one};
            end
        end
    end

    // Blink generator; a fresh mode request restarts it in the visible phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bcnt    <= '0;
            r_phase   <= 1'b1;
            r_set_d   <= 1'b0;
            r_alarm_d <= 1'b0;
        end else begin
            r_set_d   <= set_mode;
            r_alarm_d <= alarm_flash;
            if (w_rise) begin
                r_bcnt  <= '0;
                r_phase <= 1'b1;
            end else if (r_bcnt == c_bcnt_last) begin
                r_bcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_bcnt <= r_bcnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_digit  = 4'd0;
        w_is_sep = 1'b0;
        case (r_idx)
            3'd0:    w_digit = r_snap[5];
            3'd1:    w_digit = r_snap[4];
            3'd3:    w_digit = r_snap[3];
            3'd4:    w_digit = r_snap[2];
            3'd6:    w_digit = r_snap[1];
            3'd7:    w_digit = r_snap[0];
            default: w_is_sep = 1'b1;
        endcase
    end

    always_comb begin
        w_glyph = 8'h00;
        if (w_is_sep) begin
            w_glyph = c_seg_sep;
        end else begin
            case (w_digit)
                4'd0:    w_glyph = 8'hFC;
                4'd1:    w_glyph = 8'h60;
                4'd2:    w_glyph = 8'hDA;
                4'd3:    w_glyph = 8'hF2;
                4'd4:    w_glyph = 8'h66;
                4'd5:    w_glyph = 8'hB6;
                4'd6:    w_glyph = 8'hBE;
                4'd7:    w_glyph = 8'hE0;
                4'd8:    w_glyph = 8'hFE;
                4'd9:    w_glyph = 8'hF6;
                default: w_glyph = 8'h00;
            endcase
        end
    end

    // Cursor digit number to scan position; separators are never targets
    always_comb begin
        w_cursor_vld = 1'b1;
        w_cursor_idx = 3'd0;
        case (edit_pos)
            3'd0:    w_cursor_idx = 3'd0;
            3'd1:    w_cursor_idx = 3'd1;
            3'd2:    w_cursor_idx = 3'd3;
            3'd3:    w_cursor_idx = 3'd4;
            3'd4:    w_cursor_idx = 3'd6;
            3'd5:    w_cursor_idx = 3'd7;
            default: w_cursor_vld = 1'b0;
        endcase
    end

    assign w_blank = ~r_phase &
                     (alarm_flash |
                      (set_mode & w_cursor_vld & (w_cursor_idx == r_idx)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_data <= 8'h00;
            seg_com  <= 8'hFF;
        end else begin
            seg_data <= w_blank ? 8'h00 : w_glyph;
            seg_com  <= ~(8'h80 >> r_idx);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_display_scan
// Description : Scoreboard bench for seg_display_scan plus directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_display_scan;

    localparam int SCAN_DIV   = 1;
    localparam int BLINK_HALF = 500;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] h_ten = 4'd0, h_one = 4'd0, m_ten = 4'd0;
    logic [3:0] m_one = 4'd0, s_ten = 4'd0, s_one = 4'd0;
    logic       set_mode = 1'b0;
    logic [2:0] edit_pos = 3'd7;
    logic       alarm_flash = 1'b0;
    logic [7:0] seg_data;
    logic [7:0] seg_com;

    int checks = 0;
    int errors = 0;

    logic [15:0] sb_q[$];

    // Reference model state
    int          m_idx = 0, m_div = 0, m_bcnt = 0, m_cur = 0;
    bit          m_phase = 1'b1, m_set_prev = 1'b0, m_alarm_prev = 1'b0, m_blank = 1'b0;
    logic [23:0] m_snap = '0;
    logic [7:0]  e_com, e_data;
    logic [15:0] sb_exp;

    seg_display_scan #(
        .SCAN_DIV   (SCAN_DIV),
        .BLINK_HALF (BLINK_HALF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .h_ten       (h_ten),
        .h_one       (h_one),
        .m_ten       (m_ten),
        .m_one       (m_one),
        .s_ten       (s_ten),
        .s_one       (s_one),
        .set_mode    (set_mode),
        .edit_pos    (edit_pos),
        .alarm_flash (alarm_flash),
        .seg_data    (seg_data),
        .seg_com     (seg_com)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 8'hFC;  4'd1: return 8'h60;  4'd2: return 8'hDA;
            4'd3: return 8'hF2;  4'd4: return 8'h66;  4'd5: return 8'hB6;
            4'd6: return 8'hBE;  4'd7: return 8'hE0;  4'd8: return 8'hFE;
            4'd9: return 8'hF6;  default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] frame_val(input int p, input logic [23:0] d);
        case (p)
            0: return seg_of(d[23:20]);
            1: return seg_of(d[19:16]);
            3: return seg_of(d[15:12]);
            4: return seg_of(d[11:8]);
            6: return seg_of(d[7:4]);
            7: return seg_of(d[3:0]);
            default: return 8'h02;
        endcase
    endfunction

    function automatic logic [23:0] live_digits();
        return {h_ten, h_one, m_ten, m_one, s_ten, s_one};
    endfunction

    function automatic int com_pos(input logic [7:0] com);
        int p;
        p = -1;
        for (int k = 0; k < 8; k++) begin
            if (com == ~(8'h80 >> k)) p = k;
        end
        return p;
    endfunction

    // Model: predicts the outputs registered at each rising edge
    initial forever begin
        @(posedge clk);
        if (!rst) begin
            m_idx = 0; m_div = 0; m_bcnt = 0; m_phase = 1'b1;
            m_snap = '0; m_set_prev = 1'b0; m_alarm_prev = 1'b0;
            sb_q.delete();
        end else begin
            case (edit_pos)
                3'd0: m_cur = 0;  3'd1: m_cur = 1;  3'd2: m_cur = 3;
                3'd3: m_cur = 4;  3'd4: m_cur = 6;  3'd5: m_cur = 7;
                default: m_cur = -1;
            endcase
            m_blank = !m_phase && (alarm_flash || (set_mode && m_cur == m_idx));
            e_com = 8'hFF;
            e_com[7 - m_idx] = 1'b0;
            e_data = m_blank ? 8'h00 : frame_val(m_idx, m_snap);
            sb_q.push_back({e_com, e_data});
            if (m_idx == 7 && m_div == SCAN_DIV - 1) m_snap = live_digits();
            if (m_div == SCAN_DIV - 1) begin
                m_div = 0;
                m_idx = (m_idx + 1) % 8;
            end else begin
                m_div = m_div + 1;
            end
            if ((set_mode && !m_set_prev) || (alarm_flash && !m_alarm_prev)) begin
                m_bcnt = 0;
                m_phase = 1'b1;
            end else if (m_bcnt == BLINK_HALF - 1) begin
                m_bcnt = 0;
                m_phase = !m_phase;
            end else begin
                m_bcnt = m_bcnt + 1;
            end
            m_set_prev = set_mode;
            m_alarm_prev = alarm_flash;
        end
    end

    // Scoreboard consumer
    initial forever begin
        @(negedge clk);
        if (rst && sb_q.size() > 0) begin
            sb_exp = sb_q.pop_front();
            checks++;
            if ({seg_com, seg_data} !== sb_exp) begin
                errors++;
                $display("FAIL scoreboard t=%0t: com=%h data=%h, expected com=%h data=%h",
                         $time, seg_com, seg_data, sb_exp[15:8], sb_exp[7:0]);
            end
        end
    end

    task automatic wait_com(input logic [7:0] v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (seg_com == v) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (seg_com !== 8'hFF || seg_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold: com=%h data=%h, expected FF/00", seg_com, seg_data);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (seg_com !== 8'h7F || seg_data !== 8'hFC) begin
            errors++;
            $display("FAIL reset_first_edge: com=%h data=%h, expected 7F/FC", seg_com, seg_data);
        end
    endtask

    task automatic test_scan();
        logic [7:0] exp_data [8];
        logic [7:0] exp_com  [8];
        bit ok;
        exp_data = '{8'h60, 8'hDA, 8'h02, 8'hF2, 8'h66, 8'h02, 8'hB6, 8'hBE};
        exp_com  = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
        @(negedge clk);
        {h_ten, h_one, m_ten, m_one, s_ten, s_one} = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        repeat (16) @(negedge clk);
        wait_com(8'h7F, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL scan_sync: com=%h never reached 7F", seg_com);
        end
        for (int p = 0; p < 8; p++) begin
            checks++;
            if (seg_com !== exp_com[p] || seg_data !== exp_data[p]) begin
                errors++;
                $display("FAIL scan_pos%0d: com=%h data=%h, expected %h/%h",
                         p, seg_com, seg_data, exp_com[p], exp_data[p]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_tear();
        bit ok;
        wait_com(8'hDF, ok);
        s_one = 4'd7;
        wait_com(8'hFE, ok);
        checks++;
        if (!ok || seg_data !== 8'hBE) begin
            errors++;
            $display("FAIL tear_same_frame: data=%h ok=%0d, expected BE", seg_data, ok);
        end
        wait_com(8'hFE, ok);
        checks++;
        if (!ok || seg_data !== 8'hE0) begin
            errors++;
            $display("FAIL tear_next_frame: data=%h ok=%0d, expected E0", seg_data, ok);
        end
    endtask

    task automatic test_cursor();
        int p;
        logic [7:0] want;
        @(negedge clk);
        edit_pos = 3'd3;
        set_mode = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 2 * BLINK_HALF; n++) begin
            @(posedge clk);
            #1;
            p = com_pos(seg_com);
            if (p == 4) want = (n <= BLINK_HALF) ? 8'h66 : 8'h00;
            else want = frame_val(p, live_digits());
            checks++;
            if (p < 0 || seg_data !== want) begin
                errors++;
                $display("FAIL cursor n=%0d: com=%h data=%h, expected data %h", n, seg_com, seg_data, want);
            end
        end
    endtask

    task automatic test_alarm();
        int p;
        logic [7:0] want;
        @(negedge clk);
        alarm_flash = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 2 * BLINK_HALF; n++) begin
            @(posedge clk);
            #1;
            p = com_pos(seg_com);
            want = (n <= BLINK_HALF) ? frame_val(p, live_digits()) : 8'h00;
            checks++;
            if (p < 0 || seg_data !== want) begin
                errors++;
                $display("FAIL alarm n=%0d: com=%h data=%h, expected data %h", n, seg_com, seg_data, want);
            end
        end
    endtask

    task automatic test_invalid_and_reset();
        bit ok;
        @(negedge clk);
        alarm_flash = 1'b0;
        set_mode = 1'b0;
        m_ten = 4'hA;
        repeat (20) @(negedge clk);
        wait_com(8'hEF, ok);
        checks++;
        if (!ok || seg_data !== 8'h00) begin
            errors++;
            $display("FAIL invalid_digit: data=%h ok=%0d, expected 00", seg_data, ok);
        end
        wait_com(8'hF7, ok);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (!ok || seg_com !== 8'hFF || seg_data !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: com=%h data=%h ok=%0d, expected FF/00", seg_com, seg_data, ok);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (seg_com !== 8'h7F || seg_data !== 8'hFC) begin
            errors++;
            $display("FAIL restart_after_reset: com=%h data=%h, expected 7F/FC", seg_com, seg_data);
        end
        repeat (24) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_scan();
        test_tear();
        test_cursor();
        test_alarm();
        test_invalid_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
